// File: rtl/instr_imm_encoder_pkg.sv
// rv_pkg: shared immediate-format encoding, used by the immediate
// encoder, the datapath extender and the control decoder.
//   IMM_I/S/B/J : 2-bit immsrc codes
//   enc_res_t   : scatter result (instr[31:7] plus range error)
//   upper_uniform(): true when v[31:lsb] are all equal, so the value
//                    fits a signed field whose MSB is bit lsb
package rv_pkg;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic [24:0] instr;
    logic        err;
  } enc_res_t;

  function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << lsb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction
endpackage

// File: rtl/instr_imm_encoder_if.sv
// Request/response bus of the immediate encoder.
//   in_*  : request side (valid/ready, immsrc, imm, base = instr[31:7])
//   out_* : encoded-word side (valid/ready, instr[31:7], err)
// slave = encoder, master = producer/consumer (bench, generator).
interface instr_imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [24:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_instr;
  logic        out_err;

  modport slave (
    input  in_valid, in_immsrc, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
  modport master (
    output in_valid, in_immsrc, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_imm_encoder_imm_scatter.sv
// imm_scatter: combinational inverse of the immediate extender.
//   immsrc_i : format select (IMM_I/S/B/J)
//   imm_i    : signed immediate (byte offset for B/J)
//   base_i   : instr[31:7] carrying the non-immediate fields
//   instr_o  : base_i with the immediate scattered into place
//   err_o    : immediate not representable (range or alignment)
// Out-of-range values are still scattered with truncated bits.
module imm_scatter
  import rv_pkg::*;
(
  input  logic [1:0]  immsrc_i,
  input  logic [31:0] imm_i,
  input  logic [24:0] base_i,
  output logic [24:0] instr_o,
  output logic        err_o
);
  // instr bit n lives at instr_o[n-7]
  always_comb begin
    instr_o = base_i;
    err_o   = 1'b0;
    case (immsrc_i)
      IMM_I: begin
        instr_o[24:13] = imm_i[11:0];
        err_o          = !upper_uniform(imm_i, 11);
      end
      IMM_S: begin
        instr_o[24:18] = imm_i[11:5];
        instr_o[4:0]   = imm_i[4:0];
        err_o          = !upper_uniform(imm_i, 11);
      end
      IMM_B: begin
        instr_o[24]    = imm_i[12];
        instr_o[0]     = imm_i[11];
        instr_o[23:18] = imm_i[10:5];
        instr_o[4:1]   = imm_i[4:1];
        err_o          = !upper_uniform(imm_i, 12) || imm_i[0];
      end
      default: begin  // IMM_J
        instr_o[24]    = imm_i[20];
        instr_o[12:5]  = imm_i[19:12];
        instr_o[13]    = imm_i[11];
        instr_o[23:14] = imm_i[10:1];
        err_o          = !upper_uniform(imm_i, 20) || imm_i[0];
      end
    endcase
  end
endmodule

// File: rtl/instr_imm_encoder.sv
// instr_imm_encoder: encodes a signed immediate into an RV32I
// instruction word (I/S/B/J) with a range/alignment check.
//   clk, reset : clock, async active-low reset
//   bus        : request/encoded-word handshake (slave side)
//   clr_err    : synchronous clear of err_count (wins over increment)
//   err_count  : saturating count of accepted errored requests
// Two register stages (S1 = scatter result, S2 = output). in_ready is
// combinational from out_ready so a full pipe still streams 1/cycle.
module instr_imm_encoder
  import rv_pkg::*;
#(
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  instr_imm_encoder_if.slave  bus,
  input  logic                clr_err,
  output logic [ERRCNT_W-1:0] err_count
);
  logic [24:0]         sc_instr;
  logic                sc_err;
  logic                s1_vld_q, out_vld_q;
  enc_res_t            s1_q, out_q;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic                s1_take, s2_take, in_fire;

  imm_scatter u_scatter (
    .immsrc_i (bus.in_immsrc),
    .imm_i    (bus.in_imm),
    .base_i   (bus.in_base),
    .instr_o  (sc_instr),
    .err_o    (sc_err)
  );

  assign s2_take      = !out_vld_q || bus.out_ready;
  assign s1_take      = !s1_vld_q || s2_take;
  assign in_fire      = bus.in_valid && s1_take;
  assign bus.in_ready = s1_take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      errcnt_q  <= '0;
    end else begin
      if (s1_take) begin
        s1_vld_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= '{instr: sc_instr, err: sc_err};
      end
      if (s2_take) begin
        out_vld_q <= s1_vld_q;
        if (s1_vld_q) out_q <= s1_q;
      end
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    errcnt_d = errcnt_q;
    if (clr_err)
      errcnt_d = '0;
    else if (in_fire && sc_err && !(&errcnt_q))
      errcnt_d = errcnt_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_instr = out_q.instr;
  assign bus.out_err   = out_q.err;
  assign err_count     = errcnt_q;
endmodule

// File: tb/tb_instr_imm_encoder.sv
module tb_instr_imm_encoder;
  import rv_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] err_count;

  instr_imm_encoder_if bus ();

  instr_imm_encoder #(.ERRCNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_err   (clr_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] imm;
    logic [24:0] base;
  } req_t;

  req_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cnt_m = 0;
  bit          last_acc, last_pop;
  logic [24:0] last_instr;
  logic        last_err;
  bit          hold_v = 0;
  logic [24:0] hold_instr;
  logic        hold_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int fw(input logic [1:0] f);
    case (f)
      IMM_I, IMM_S: return 12;
      IMM_B:        return 13;
      default:      return 21;
    endcase
  endfunction

  // value the extender must recover: low field bits sign-extended, B/J even
  function automatic logic [31:0] exp_value(input logic [1:0] f, input logic [31:0] imm);
    logic signed [31:0] t;
    int w;
    w = fw(f);
    t = imm;
    t = t <<< (32 - w);
    t = t >>> (32 - w);
    if (f[1]) t[0] = 1'b0;
    return t;
  endfunction

  function automatic logic exp_err(input logic [1:0] f, input logic [31:0] imm);
    longint s, lo, hi;
    int w;
    w  = fw(f);
    s  = longint'(signed'(imm));
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    return (s < lo) || (s > hi) || (f[1] && imm[0]);
  endfunction

  // instr[31:7] bits that are not immediate and must come from base
  function automatic logic [24:0] keep_mask(input logic [1:0] f);
    logic [31:0] m;
    case (f)
      IMM_I:        m = 32'hFFF0_0000;
      IMM_S, IMM_B: m = 32'hFE00_0F80;
      default:      m = 32'hFFFF_F000;
    endcase
    m = ~m;
    return m[31:7];
  endfunction

  // reference immediate extender
  function automatic logic [31:0] ext(input logic [24:0] w, input logic [1:0] f);
    logic [31:0] i;
    i = {w, 7'b0};
    case (f)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_in_range(input logic [1:0] f);
    return exp_value(f, $urandom);
  endfunction

  // one clock: sample at negedge, score, then advance to posedge+1
  task automatic cycle();
    req_t r;
    @(negedge clk);
    last_acc = bus.in_valid && bus.in_ready;
    last_pop = 0;
    chk("err_count", err_count, cnt_m);
    chk("in_flight_le2", q.size() <= 2, 1);
    if (hold_v) begin
      chk("hold_instr", bus.out_instr, hold_instr);
      chk("hold_err", bus.out_err, hold_err);
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("word_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("roundtrip", ext(bus.out_instr, r.f), exp_value(r.f, r.imm));
        chk("base_bits", bus.out_instr & keep_mask(r.f), r.base & keep_mask(r.f));
        chk("out_err", bus.out_err, exp_err(r.f, r.imm));
      end
      last_pop   = 1;
      last_instr = bus.out_instr;
      last_err   = bus.out_err;
    end
    hold_v     = bus.out_valid && !bus.out_ready;
    hold_instr = bus.out_instr;
    hold_err   = bus.out_err;
    if (last_acc) q.push_back('{bus.in_immsrc, bus.in_imm, bus.in_base});
    if (clr_err) cnt_m = 0;
    else if (last_acc && exp_err(bus.in_immsrc, bus.in_imm) && cnt_m < 255) cnt_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [31:0] imm, input logic [24:0] base);
    bus.in_valid  = 1'b1;
    bus.in_immsrc = f;
    bus.in_imm    = imm;
    bus.in_base   = base;
  endtask

  task automatic single(input logic [1:0] f, input logic [31:0] imm, input logic [24:0] base);
    int n;
    drive(f, imm, base);
    bus.out_ready = 1'b1;
    cycle();
    chk("single_accept", last_acc, 1);
    bus.in_valid = 1'b0;
    n = 0;
    last_pop = 0;
    while (!last_pop && n < 10) begin
      cycle();
      n++;
    end
    chk("latency_edges", n, 2);
  endtask

  task automatic send(input logic [1:0] f, input logic [31:0] imm, input logic [24:0] base,
                      input bit rnd);
    int g;
    drive(f, imm, base);
    g = 0;
    do begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      g++;
    end while (!last_acc && g < 50);
    chk("send_accept", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    g = 0;
    while (q.size() > 0 && g < 20) begin
      cycle();
      g++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int acc, pc, g;
    logic [1:0] f;
    bus.in_valid  = 1'b0;
    bus.in_immsrc = IMM_I;
    bus.in_imm    = '0;
    bus.in_base   = '0;
    bus.out_ready = 1'b1;

    // reset state while held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // directed formats
    single(IMM_I, 32'hFFFF_F800, 25'h0);
    chk("I_min_field", last_instr[24:13], 12'h800);
    chk("I_min_err", last_err, 0);
    single(IMM_I, 32'h0000_0800, 25'h0);
    chk("I_over_err", last_err, 1);
    chk("I_over_cnt", err_count, 1);
    single(IMM_B, 32'hFFFF_FFFC, 25'h0);
    chk("B_b31", last_instr[24], 1);
    chk("B_b7", last_instr[0], 1);
    chk("B_30_25", last_instr[23:18], 6'h3F);
    chk("B_11_8", last_instr[4:1], 4'hE);
    chk("B_err", last_err, 0);
    single(IMM_B, 32'h0000_0003, 25'h0);
    chk("B_odd_err", last_err, 1);
    single(IMM_B, 32'h0000_1000, 25'h0);
    chk("B_over_err", last_err, 1);
    single(IMM_J, 32'h000F_FFFE, 25'h15);
    chk("J_b31", last_instr[24], 0);
    chk("J_19_12", last_instr[12:5], 8'hFF);
    chk("J_b20", last_instr[13], 1);
    chk("J_30_21", last_instr[23:14], 10'h3FF);
    chk("J_base_11_7", last_instr[4:0], 5'h15);
    chk("J_err", last_err, 0);
    single(IMM_J, 32'h0010_0000, 25'h0);
    chk("J_over_err", last_err, 1);
    chk("directed_cnt", err_count, 4);

    // backpressure: only two words fit while the consumer stalls
    bus.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      if (acc < 4) drive(IMM_I, 32'(acc * 17 - 20), 25'(acc + 1));
      cycle();
      if (last_acc) acc++;
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    pc = 0;
    for (int k = 0; k < 4; k++) begin
      if (acc < 4) drive(IMM_I, 32'(acc * 17 - 20), 25'(acc + 1));
      else bus.in_valid = 1'b0;
      cycle();
      if (last_acc) acc++;
      if (last_pop) pc++;
    end
    chk("bp_accepts_all", acc, 4);
    chk("bp_pops_per_cycle", pc, 4);
    drain();

    // reset with two words in flight
    bus.out_ready = 1'b0;
    acc = 0;
    g = 0;
    while (acc < 2 && g < 10) begin
      drive(IMM_S, 32'h0000_0900, 25'h1ABCD);
      cycle();
      if (last_acc) acc++;
      g++;
    end
    bus.in_valid = 1'b0;
    chk("mid_accepts", acc, 2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    q.delete();
    cnt_m  = 0;
    hold_v = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("no_stale_word", bus.out_valid, 0);
    end

    // random in-range round trip per format with random stalls
    for (int fi = 0; fi < 4; fi++) begin
      f = 2'(fi);
      for (int n = 0; n < 1000; n++)
        send(f, rand_in_range(f), 25'($urandom), 1'b1);
    end
    drain();
    chk("rt_no_errors", err_count, 0);

    // saturation: 300 errored requests
    for (int n = 0; n < 300; n++)
      send(2'($urandom), ($urandom & 32'h7FFF_FFFF) | 32'h4000_0000, 25'($urandom), 1'b0);
    drain();
    chk("sat_err_count", err_count, 255);

    // clear wins over a simultaneous error
    drive(IMM_I, 32'h0000_0800, 25'h0);
    clr_err = 1'b1;
    cycle();
    chk("clr_accept", last_acc, 1);
    clr_err = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_priority", err_count, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
